refresh_sched: RTL

- Refresh-request scheduler directly upstream of the RAM controller.
- Produces the RefReq / RefUrgent pair that the RAM block consumes, plus the RAS-only refresh row address.
- Runs on FCLK and replaces the C8M-derived request path, so refresh rate tracks the accelerated FSB clock.
- Accumulates owed refreshes while the FSB is busy, escalates to urgent, and retires one refresh per RAM acknowledge.

---
 rtl/refresh_sched_pkg.sv | 25 ++
 rtl/refresh_sched_if.sv | 26 ++
 rtl/refresh_sched_prescaler.sv | 27 ++
 rtl/refresh_sched.sv | 100 ++++++++++
 4 files changed

// File: rtl/refresh_sched_pkg.sv
// Shared types and default timing for the refresh scheduler.
// DEF_PERIOD is derived from the DRAM refresh slot length and the FSB clock rate.
package refresh_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    URG  = 2'd2
  } ref_state_t;

  localparam int SLOT_NS  = 15600;
  localparam int FCLK_MHZ = 25;

  function automatic int slot_cycles(input int mhz);
    return (mhz * SLOT_NS) / 1000;
  endfunction

  localparam int DEF_PERIOD       = slot_cycles(FCLK_MHZ);
  localparam int DEF_URGENT_LEVEL = 2;
  localparam int DEF_MAX_PEND     = 4;
  localparam int DEF_ROW_BITS     = 9;
  localparam int PRE_W            = 12;
  localparam int PEND_W           = 3;

endpackage

// File: rtl/refresh_sched_if.sv
// Refresh request bundle between the scheduler (slave) and the RAM controller / FSB side (master).
interface refresh_sched_if
  import refresh_sched_pkg::*;
#(
  parameter int ROW_BITS = DEF_ROW_BITS
);
  logic                RefEn;
  logic                BACT;
  logic                RefAck;
  logic                RefReq;
  logic                RefUrgent;
  logic                RefIdleOK;
  logic [ROW_BITS-1:0] RefRow;
  logic                RefOvf;
  logic                RefErr;

  modport master (
    output RefEn, BACT, RefAck,
    input  RefReq, RefUrgent, RefIdleOK, RefRow, RefOvf, RefErr
  );

  modport slave (
    input  RefEn, BACT, RefAck,
    output RefReq, RefUrgent, RefIdleOK, RefRow, RefOvf, RefErr
  );
endinterface

// File: rtl/refresh_sched_prescaler.sv
// Modulo-PERIOD counter; tick is combinational in the last count while enabled.
// Disabling holds the count in place so a paused interval resumes where it stopped.
module refresh_sched_prescaler
  import refresh_sched_pkg::*;
#(
  parameter int PERIOD = DEF_PERIOD,
  parameter int W      = PRE_W
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/refresh_sched.sv
// Refresh-request scheduler: owes one refresh per prescaler slot, retires one per RAM ack.
// Outputs are registered from the next-cycle debt, so they move 1 FCLK after tick/ack.
module refresh_sched
  import refresh_sched_pkg::*;
#(
  parameter int PERIOD       = DEF_PERIOD,
  parameter int URGENT_LEVEL = DEF_URGENT_LEVEL,
  parameter int MAX_PEND     = DEF_MAX_PEND,
  parameter int ROW_BITS     = DEF_ROW_BITS
) (
  input  logic           FCLK,
  input  logic           RES,
  refresh_sched_if.slave bus
);
  localparam logic [PEND_W-1:0] MAXP = PEND_W'(MAX_PEND);
  localparam logic [PEND_W-1:0] URGL = PEND_W'(URGENT_LEVEL);

  logic                tick;
  logic [PEND_W-1:0]   pend;
  logic [PEND_W-1:0]   pend_nxt;
  logic                ack_ok;
  logic                ovf_hit;
  logic                err_hit;
  ref_state_t          state;
  logic [ROW_BITS-1:0] row;
  logic                req_q, urg_q, idle_q, ovf_q, err_q;

  refresh_sched_prescaler #(.PERIOD(PERIOD), .W(PRE_W)) u_pre (
    .clk  (FCLK),
    .rst  (RES),
    .en   (bus.RefEn),
    .tick (tick)
  );

  // A tick and an ack in the same cycle cancel, even at zero debt: that is an immediate retire.
  always_comb begin
    pend_nxt = pend;
    ack_ok   = 1'b0;
    ovf_hit  = 1'b0;
    err_hit  = 1'b0;
    if (tick && !bus.RefAck) begin
      if (pend == MAXP) ovf_hit = 1'b1;
      else              pend_nxt = pend + 1'b1;
    end else if (!tick && bus.RefAck) begin
      if (pend == '0) begin
        err_hit = 1'b1;
      end else begin
        pend_nxt = pend - 1'b1;
        ack_ok   = 1'b1;
      end
    end else if (tick && bus.RefAck) begin
      ack_ok = 1'b1;
    end
  end

  always_ff @(posedge FCLK) begin
    if (RES) begin
      pend   <= '0;
      row    <= '0;
      state  <= IDLE;
      req_q  <= 1'b0;
      urg_q  <= 1'b0;
      idle_q <= 1'b0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (ack_ok)  row   <= row + 1'b1;
      if (ovf_hit) ovf_q <= 1'b1;
      if (err_hit) err_q <= 1'b1;
      // Next state follows the new debt directly, which also skips PEND when URGENT_LEVEL is 1.
      if (pend_nxt == '0) begin
        state  <= IDLE;
        req_q  <= 1'b0;
        urg_q  <= 1'b0;
        idle_q <= 1'b0;
      end else if (pend_nxt >= URGL) begin
        state  <= URG;
        req_q  <= 1'b1;
        urg_q  <= 1'b1;
        idle_q <= !bus.BACT;
      end else begin
        state  <= PEND;
        req_q  <= 1'b1;
        urg_q  <= 1'b0;
        idle_q <= !bus.BACT;
      end
    end
  end

  assign bus.RefReq    = req_q;
  assign bus.RefUrgent = urg_q;
  assign bus.RefIdleOK = idle_q;
  assign bus.RefRow    = row;
  assign bus.RefOvf    = ovf_q;
  assign bus.RefErr    = err_q;

  logic unused_state;
  assign unused_state = ^state;
endmodule
